// File: rtl/sfu_seq.sv
// sfu_seq: sequencer that bursts psum FIFO reads into SFU valid_in windows and writes SFU results to output memory
//
// Optional feature macro: SFU_SEQ_SIMD_EN (when defined, cfg_simd is latched on start
// and driven on sfu_simd for the whole job; otherwise sfu_simd is tied 0).
//
// Ports:
//   clk            in   single clock, posedge
//   reset          in   synchronous, active-high
//   start          in   begin a job (only honoured in IDLE)
//   cfg_num_acc    in   psums per output, burst length N
//   cfg_num_out    in   outputs per job, M
//   cfg_simd       in   SIMD mode request
//   fifo_count     in   psum FIFO occupancy
//   fifo_rd        out  FIFO read strobe
//   sfu_valid_in   out  SFU accumulate window (fifo_rd delayed one cycle)
//   sfu_simd       out  SFU SIMD select
//   sfu_valid_out  in   SFU result strobe
//   out_wr         out  output memory write enable
//   out_addr       out  output memory address (write counter)
//   busy           out  job in progress
//   done           out  one-cycle job-complete pulse
module sfu_seq #(
    parameter int acc_bw = 8,
    parameter int out_bw = 10,
    parameter int cnt_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [acc_bw-1:0] cfg_num_acc,
    input  logic [out_bw-1:0] cfg_num_out,
    input  logic              cfg_simd,
    input  logic [cnt_bw-1:0] fifo_count,
    output logic              fifo_rd,
    output logic              sfu_valid_in,
    output logic              sfu_simd,
    input  logic              sfu_valid_out,
    output logic              out_wr,
    output logic [out_bw-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, WAIT, ACC, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [acc_bw-1:0] acc_q, acc_d;
    logic [out_bw-1:0] num_out_q, num_out_d;
    logic [acc_bw-1:0] rd_cnt_q, rd_cnt_d;
    logic [out_bw-1:0] grp_q, grp_d;
    logic [out_bw-1:0] wr_q, wr_d;
    logic              vi_q;
    logic              accept;
    logic              burst_last;
    logic              enough;

    assign accept     = (state_q == IDLE) && start;
    assign burst_last = (rd_cnt_q + acc_bw'(1)) == acc_q;
    assign enough     = 32'(fifo_count) >= 32'(acc_q);

`ifdef SFU_SEQ_SIMD_EN
    logic simd_q;
    always_ff @(posedge clk) begin
        if (reset)
            simd_q <= 1'b0;
        else if (accept)
            simd_q <= cfg_simd;
    end
`else
    logic unused_cfg_simd;
    assign unused_cfg_simd = cfg_simd;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            num_out_q <= '0;
            rd_cnt_q  <= '0;
            grp_q     <= '0;
            wr_q      <= '0;
            vi_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            num_out_q <= num_out_d;
            rd_cnt_q  <= rd_cnt_d;
            grp_q     <= grp_d;
            wr_q      <= wr_d;
            vi_q      <= fifo_rd;
        end
    end

    // DRAIN looks at wr_d so done lands the cycle right after the last write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !start ? IDLE :
                               (cfg_num_acc == '0 || cfg_num_out == '0) ? DONE : WAIT;
            WAIT:    state_d = (grp_q == num_out_q) ? DRAIN : enough ? ACC : WAIT;
            ACC:     state_d = burst_last ? WAIT : ACC;
            DRAIN:   state_d = (wr_d == num_out_q) ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d     = accept ? cfg_num_acc : acc_q;
        num_out_d = accept ? cfg_num_out : num_out_q;
        rd_cnt_d  = (state_q == ACC && !burst_last) ? rd_cnt_q + acc_bw'(1) : '0;
        grp_d     = accept ? '0 : grp_q + {{(out_bw-1){1'b0}}, state_q == ACC && burst_last};
        wr_d      = accept ? '0 : wr_q + {{(out_bw-1){1'b0}}, out_wr};
    end

    always_comb begin
        fifo_rd      = state_q == ACC;
        busy         = state_q != IDLE;
        done         = state_q == DONE;
        out_wr       = sfu_valid_out & busy;
        out_addr     = wr_q;
        sfu_valid_in = vi_q;
`ifdef SFU_SEQ_SIMD_EN
        sfu_simd     = simd_q & busy;
`else
        sfu_simd     = 1'b0;
`endif
    end

endmodule
